// File: rtl/fp_div_stream_ctrl.sv
// fp_div_stream_ctrl
//   Issue/collect controller around a fixed-latency, non-stallable pipelined
//   FP divider. Operand pairs arrive on a valid/ready stream and are passed
//   straight through to the divider. Results are captured into a local FIFO
//   and offered downstream on a valid/ready stream. Credit counting
//   (inflight + stored <= FIFO_DEPTH) means a result always has a FIFO slot.
//   A flush FSM stops new issue and signals when all outstanding work is gone.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream operand handshake
//   in_a, in_b              dividend / divisor
//   div_a, div_b            operands to the divider (pass-through)
//   div_ab_valid            divider issue strobe
//   div_z, div_z_valid      divider result
//   out_valid/out_ready     downstream result handshake
//   out_z                   FIFO head
//   flush_req               level request to drain
//   flush_done              one-cycle pulse when the drain completes
//   busy                    work inflight or results stored
//   lat_err                 (FP_DIV_STREAM_LAT_CHECK_EN only) sticky latency error
//
// Optional feature macro: FP_DIV_STREAM_LAT_CHECK_EN
module fp_div_stream_ctrl #(
    parameter int sig_width   = 23,
    parameter int exp_width   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_LATENCY = 5,
    localparam int DW         = sig_width + exp_width + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    output logic          div_ab_valid,
    input  logic [DW-1:0] div_z,
    input  logic          div_z_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_z,
    input  logic          flush_req,
    output logic          flush_done,
    output logic          busy
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
    ,
    output logic          lat_err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (DIV_LATENCY < 1)) begin : g_bad_params
        $error("fp_div_stream_ctrl: FIFO_DEPTH must be a power of two >= 2 and DIV_LATENCY >= 1");
    end

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        HOLD
    } state_t;

    state_t          r_state;
    logic            r_flush_done;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_fifo_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [DW-1:0]   r_mem [FIFO_DEPTH];

    logic [CW:0]     w_credits_used;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;

    assign w_credits_used = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
    assign in_ready       = (r_state == RUN) && (w_credits_used < (CW + 1)'(FIFO_DEPTH));
    assign w_issue        = in_valid && in_ready;

    assign div_a          = in_a;
    assign div_b          = in_b;
    assign div_ab_valid   = w_issue;

    // A result with nothing inflight cannot belong to us (e.g. issued before
    // a reset) and is dropped rather than written.
    assign w_push         = div_z_valid && (r_inflight != '0);
    assign out_valid      = (r_fifo_cnt != '0);
    assign w_pop          = out_valid && out_ready;
    assign out_z          = r_mem[r_rd_ptr];

    assign busy           = (r_inflight != '0) || out_valid;
    assign flush_done     = r_flush_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= div_z;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // HOLD is the post-DONE wait for flush_req to fall; flush_done is high
    // only for the single cycle spent in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (flush_req) r_state <= DRAIN;
                end
                DRAIN: begin
                    if ((r_inflight == '0) && (r_fifo_cnt == '0)) begin
                        r_state      <= DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= flush_req ? HOLD : RUN;
                end
                HOLD: begin
                    if (!flush_req) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef FP_DIV_STREAM_LAT_CHECK_EN
    // Bit k holds the issue strobe from k+1 cycles ago; the MSB is the
    // cycle in which the divider must present the matching result.
    logic [DIV_LATENCY-1:0] r_lat_sr;
    logic                   r_lat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_sr  <= '0;
            r_lat_err <= 1'b0;
        end else begin
            r_lat_sr  <= (r_lat_sr << 1) | DIV_LATENCY'(w_issue);
            r_lat_err <= r_lat_err | (div_z_valid != r_lat_sr[DIV_LATENCY-1]);
        end
    end

    assign lat_err = r_lat_err;
`endif

endmodule

// File: tb/tb_fp_div_stream_ctrl.sv
module tb_fp_div_stream_ctrl;

    localparam int SW  = 23;
    localparam int EW  = 8;
    localparam int DEP = 8;
    localparam int L   = 5;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;
    localparam int M_HOLD  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ab_valid;
    logic [31:0] div_z;
    logic        div_z_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        flush_req;
    logic        flush_done;
    logic        busy;
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
    logic        lat_err;
`endif

    always #5 clk = ~clk;

    fp_div_stream_ctrl #(
        .sig_width  (SW),
        .exp_width  (EW),
        .FIFO_DEPTH (DEP),
        .DIV_LATENCY(L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_ab_valid(div_ab_valid),
        .div_z       (div_z),
        .div_z_valid (div_z_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .busy        (busy)
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
        ,
        .lat_err     (lat_err)
`endif
    );

    // Single-precision divide through real arithmetic (normal operands only).
    function automatic real sp2real(input logic [31:0] f);
        logic [10:0] e;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(sp2real(a) / sp2real(b));
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(120, 134));
        r[22:0]  = 23'($urandom);
        return r;
    endfunction

    // Divider stand-in: fixed latency, no stall, keeps running through reset.
    logic [L-1:0] pipe_v = '0;
    logic [31:0]  pipe_d [L];
    logic         inj_v = 1'b0;

    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        pipe_v[0] <= div_ab_valid;
        pipe_d[0] <= div_ab_valid ? fdiv(div_a, div_b) : 32'd0;
    end

    assign div_z_valid = pipe_v[L-1] | inj_v;
    assign div_z       = inj_v ? 32'hDEAD_BEEF : pipe_d[L-1];

    // Reference model: every issued-but-not-delivered result with the step
    // index at which it becomes visible downstream.
    typedef struct {
        logic [31:0] z;
        int          avail;
    } ent_t;

    ent_t q[$];
    logic hist[$];
    int   mode;
    int   cyc;
    logic exp_lat;

    int n_tests;
    int n_fail;
    int n_obs_issue;
    int n_obs_deliv;
    int n_obs_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fr, output logic acc);
        logic exp_ir;
        logic exp_ov;
        logic empty_now;
        logic tracked;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush_req = fr;
        #1;
        exp_ir = (mode == M_RUN) && (q.size() < DEP);
        exp_ov = (q.size() != 0) && (q[0].avail <= cyc);
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("div_ab_valid", 64'(div_ab_valid), 64'(v && exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) chk("out_z", 64'(out_z), 64'(q[0].z));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("flush_done", 64'(flush_done), 64'(mode == M_DONE));
        if (v) begin
            chk("div_a", 64'(div_a), 64'(a));
            chk("div_b", 64'(div_b), 64'(b));
        end
        tracked = (hist.size() >= L) ? hist[hist.size() - L] : 1'b0;
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
        chk("lat_err", 64'(lat_err), 64'(exp_lat));
`endif
        if (div_z_valid !== tracked) exp_lat = 1'b1;
        if (div_ab_valid === 1'b1) n_obs_issue++;
        if ((out_valid === 1'b1) && ordy) n_obs_deliv++;
        if (flush_done === 1'b1) n_obs_done++;

        empty_now = (q.size() == 0);
        acc = v && exp_ir;
        if (exp_ov && ordy) void'(q.pop_front());
        if (acc) q.push_back('{fdiv(a, b), cyc + L + 1});
        hist.push_back(acc);
        case (mode)
            M_RUN:   if (fr) mode = M_DRAIN;
            M_DRAIN: if (empty_now) mode = M_DONE;
            M_DONE:  mode = fr ? M_HOLD : M_RUN;
            default: if (!fr) mode = M_RUN;
        endcase
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_div_ab_valid"}, 64'(div_ab_valid), 64'd0);
        chk({tag, "_flush_done"}, 64'(flush_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_out_z"}, 64'(out_z), 64'd0);
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
        chk({tag, "_lat_err"}, 64'(lat_err), 64'd0);
`endif
    endtask

    initial begin
        logic        acc;
        logic [31:0] ca;
        logic [31:0] cb;
        logic [31:0] ops_a [12];
        logic [31:0] ops_b [12];
        int          idx;
        int          base_i;
        int          base_d;

        n_tests = 0; n_fail = 0; n_obs_issue = 0; n_obs_deliv = 0; n_obs_done = 0;
        mode = M_RUN; cyc = 0; exp_lat = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; flush_req = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Single op: 6.0 / 2.0
        step(1'b1, 32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b0, acc);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) chk("single_not_yet", 64'(out_valid), 64'd0);
            if (k == 5) begin
                chk("single_valid", 64'(out_valid), 64'd1);
                chk("single_z", 64'(out_z), 64'h4040_0000);
            end
            if (k == 6) chk("single_busy_clear", 64'(busy), 64'd0);
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        end

        // Backpressure: 12 ops offered with out_ready low
        for (int i = 0; i < 12; i++) begin
            ops_a[i] = rnd_op();
            ops_b[i] = rnd_op();
        end
        idx = 0; base_i = n_obs_issue; base_d = n_obs_deliv;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, ops_a[idx], ops_b[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(n_obs_issue - base_i), 64'd8);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 40; i++) begin
            step(idx < 12, ops_a[idx % 12], ops_b[idx % 12], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_issued_total", 64'(n_obs_issue - base_i), 64'd12);
        chk("bp_delivered", 64'(n_obs_deliv - base_d), 64'd12);

        // Full throughput
        base_i = n_obs_issue; base_d = n_obs_deliv;
        for (int i = 0; i < 100; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("tp_issued", 64'(n_obs_issue - base_i), 64'd100);
        chk("tp_delivered", 64'(n_obs_deliv - base_d), 64'd100);

        // Random traffic with held operands while not accepted
        ca = rnd_op(); cb = rnd_op();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), ca, cb, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                ca = rnd_op(); cb = rnd_op();
            end
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("mix_idle", 64'(busy), 64'd0);

        // Flush with 3 inflight and 2 stored
        for (int i = 0; i < 5; i++) step(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, acc);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        base_d = n_obs_deliv; n_obs_done = 0;
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
        chk("flush_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 14; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1, acc);
        chk("flush_delivered", 64'(n_obs_deliv - base_d), 64'd5);
        chk("flush_pulses", 64'(n_obs_done), 64'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 8; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Stray result with nothing inflight
        inj_v = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        inj_v = 1'b0;
        chk("stray_out_valid", 64'(out_valid), 64'd0);
`ifdef FP_DIV_STREAM_LAT_CHECK_EN
        chk("stray_lat_err", 64'(lat_err), 64'd1);
`endif
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Reset with 4 results inside the divider
        for (int i = 0; i < 4; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete(); hist.delete(); mode = M_RUN; exp_lat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("late_out_valid", 64'(out_valid), 64'd0);
        chk("late_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
